// File: rtl/imem_load_ctrl_pkg.sv
// Shared types and sizing for the instruction-memory load controller.
// Holds the FSM state encoding and the default memory geometry.
package imem_load_ctrl_pkg;

    localparam int ADDR_W_DEF     = 8;
    localparam int DATA_W_DEF     = 32;
    localparam int BYTES_PER_WORD = 4;
    localparam int BYTE_CNT_W     = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RECV  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/imem_load_ctrl_if.sv
// Bundle of fetch, loader-byte and instruction-memory signals around the controller.
// The slave modport is the controller side; master is the fetch/host/memory side.
interface imem_load_ctrl_if
    import imem_load_ctrl_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) ();

    logic [ADDR_W-1:0] fetch_addr;
    logic              load_start;
    logic [ADDR_W-1:0] load_base;
    logic [ADDR_W:0]   load_len;
    logic              load_abort;
    logic              byte_valid;
    logic [7:0]        byte_data;
    logic              byte_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    logic              cpu_stall;
    logic              load_busy;
    logic              load_done;

    modport slave (
        input  fetch_addr, load_start, load_base, load_len, load_abort,
               byte_valid, byte_data,
        output byte_ready, mem_addr, mem_wdata, mem_we, cpu_stall,
               load_busy, load_done
    );

    modport master (
        output fetch_addr, load_start, load_base, load_len, load_abort,
               byte_valid, byte_data,
        input  byte_ready, mem_addr, mem_wdata, mem_we, cpu_stall,
               load_busy, load_done
    );

endinterface

// File: rtl/imem_load_ctrl_packer.sv
// Little-endian byte-to-word assembler: byte k of a word lands in bits [8k+7:8k].
// word_full flags the accept that supplies the last byte of the word.
module imem_word_packer
    import imem_load_ctrl_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              accept,
    input  logic              clear,
    input  logic [7:0]        byte_in,
    output logic              word_full,
    output logic [DATA_W-1:0] word
);

    logic [BYTE_CNT_W-1:0] cnt;

    assign word_full = accept && (cnt == BYTE_CNT_W'(BYTES_PER_WORD - 1));

    // clear wins over accept so an aborted partial word never leaks into the next one
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt  <= '0;
            word <= '0;
        end else if (accept) begin
            word[{cnt, 3'b000} +: 8] <= byte_in;
            cnt                      <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/imem_load_ctrl.sv
// Shares the instruction-memory address port between CPU fetch and a byte-serial loader.
// Stalls the CPU for the whole load and writes each assembled word in a single cycle.
module imem_load_ctrl
    import imem_load_ctrl_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    imem_load_ctrl_if.slave   bus
);

    state_t            state;
    logic [ADDR_W-1:0] wptr;
    logic [ADDR_W:0]   remaining;
    logic              accept;
    logic              clear;
    logic              word_full;
    logic [DATA_W-1:0] word;

    // abort takes priority over a byte offered in the same cycle
    assign accept = (state == ST_RECV) && bus.byte_valid && !bus.load_abort;
    assign clear  = (state != ST_RECV);

    imem_word_packer #(.DATA_W(DATA_W)) u_packer (
        .clk       (clk),
        .rst       (rst),
        .accept    (accept),
        .clear     (clear),
        .byte_in   (bus.byte_data),
        .word_full (word_full),
        .word      (word)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            wptr      <= '0;
            remaining <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (bus.load_start) begin
                        wptr      <= bus.load_base;
                        remaining <= bus.load_len;
                        state     <= (bus.load_len == '0) ? ST_DONE : ST_RECV;
                    end
                end
                ST_RECV: begin
                    if (bus.load_abort)
                        state <= ST_DONE;
                    else if (word_full)
                        state <= ST_WRITE;
                end
                ST_WRITE: begin
                    wptr      <= wptr + 1'b1;
                    remaining <= remaining - 1'b1;
                    if (bus.load_abort || remaining == (ADDR_W+1)'(1))
                        state <= ST_DONE;
                    else
                        state <= ST_RECV;
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.byte_ready = (state == ST_RECV);
    assign bus.mem_we     = (state == ST_WRITE);
    assign bus.mem_wdata  = word;
    assign bus.cpu_stall  = (state != ST_IDLE);
    assign bus.load_busy  = (state == ST_RECV) || (state == ST_WRITE);
    assign bus.load_done  = (state == ST_DONE);
    assign bus.mem_addr   = (state == ST_IDLE) ? bus.fetch_addr : wptr;

endmodule

// File: tb/tb_imem_load_ctrl.sv
// Directed bench for imem_load_ctrl: passthrough table, then load, wrap, zero-length,
// abort and mid-load reset sequences checked against hand-computed writes.
module tb_imem_load_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    imem_load_ctrl_if #(.ADDR_W(8), .DATA_W(32)) bus ();
    imem_load_ctrl #(.ADDR_W(8), .DATA_W(32)) dut (.clk(clk), .rst(rst), .bus(bus));

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0]  a;
        logic [31:0] d;
    } wr_t;

    typedef struct {
        logic [7:0] fa;
        logic [7:0] exp_addr;
    } pv_t;

    wr_t wq[$];
    wr_t eq[$];
    int  ready_cnt = 0;
    int  done_cnt  = 0;

    always @(negedge clk) begin
        if (bus.mem_we) wq.push_back('{a: bus.mem_addr, d: bus.mem_wdata});
        if (bus.byte_ready) ready_cnt <= ready_cnt + 1;
        if (bus.load_done)  done_cnt  <= done_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string n);
        chk({n, "_byte_ready"}, 64'(bus.byte_ready), 64'd0);
        chk({n, "_mem_we"},     64'(bus.mem_we),     64'd0);
        chk({n, "_mem_wdata"},  64'(bus.mem_wdata),  64'd0);
        chk({n, "_cpu_stall"},  64'(bus.cpu_stall),  64'd0);
        chk({n, "_load_busy"},  64'(bus.load_busy),  64'd0);
        chk({n, "_load_done"},  64'(bus.load_done),  64'd0);
        chk({n, "_mem_addr"},   64'(bus.mem_addr),   64'(bus.fetch_addr));
    endtask

    task automatic start_load(input logic [7:0] base, input logic [8:0] len);
        bus.load_base  = base;
        bus.load_len   = len;
        bus.load_start = 1'b1;
        tick();
        bus.load_start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        repeat (gap) tick();
        for (int i = 0; i < 20 && !bus.byte_ready; i++) tick();
        chk("byte_ready_wait", 64'(bus.byte_ready), 64'd1);
        bus.byte_valid = 1'b1;
        bus.byte_data  = b;
        tick();
        bus.byte_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int gap);
        for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], gap);
    endtask

    task automatic wait_done(input string n);
        for (int i = 0; i < 60 && !bus.load_done; i++) tick();
        chk({n, "_load_done"}, 64'(bus.load_done), 64'd1);
        chk({n, "_stall_in_done"}, 64'(bus.cpu_stall), 64'd1);
        tick();
        chk({n, "_stall_release"}, 64'(bus.cpu_stall), 64'd0);
    endtask

    task automatic cmp_writes(input string n);
        chk({n, "_write_count"}, 64'(wq.size()), 64'(eq.size()));
        for (int i = 0; i < eq.size() && i < wq.size(); i++) begin
            chk($sformatf("%s_w%0d_addr", n, i), 64'(wq[i].a), 64'(eq[i].a));
            chk($sformatf("%s_w%0d_data", n, i), 64'(wq[i].d), 64'(eq[i].d));
        end
        wq.delete();
        eq.delete();
    endtask

    pv_t pt[3];
    int  rc0;
    int  dc0;

    initial begin
        pt[0] = '{fa: 8'h00, exp_addr: 8'h00};
        pt[1] = '{fa: 8'h05, exp_addr: 8'h05};
        pt[2] = '{fa: 8'hFF, exp_addr: 8'hFF};

        bus.fetch_addr = 8'h00;
        bus.load_start = 1'b0;
        bus.load_base  = '0;
        bus.load_len   = '0;
        bus.load_abort = 1'b0;
        bus.byte_valid = 1'b0;
        bus.byte_data  = '0;

        rst = 1'b1;
        tick();
        tick();
        check_reset_outputs("reset");
        rst = 1'b0;
        tick();

        // idle passthrough
        for (int i = 0; i < 3; i++) begin
            bus.fetch_addr = pt[i].fa;
            #1;
            chk($sformatf("pass%0d_addr", i), 64'(bus.mem_addr), 64'(pt[i].exp_addr));
            chk($sformatf("pass%0d_stall", i), 64'(bus.cpu_stall), 64'd0);
            chk($sformatf("pass%0d_we", i), 64'(bus.mem_we), 64'd0);
            tick();
        end
        wq.delete();

        // single word
        start_load(8'h03, 9'd1);
        chk("single_busy", 64'(bus.load_busy), 64'd1);
        send_word(32'h00402183, 0);
        chk("single_we",    64'(bus.mem_we),     64'd1);
        chk("single_addr",  64'(bus.mem_addr),   64'h03);
        chk("single_wdata", 64'(bus.mem_wdata),  64'h00402183);
        chk("single_ready", 64'(bus.byte_ready), 64'd0);
        wait_done("single");
        eq.push_back('{a: 8'h03, d: 32'h00402183});
        cmp_writes("single");

        // multi-word with wrap, gaps and an ignored load_start
        dc0 = done_cnt;
        start_load(8'hFE, 9'd3);
        send_word(32'h44332211, 1);
        bus.load_base  = 8'h40;
        bus.load_len   = 9'd1;
        bus.load_start = 1'b1;
        tick();
        bus.load_start = 1'b0;
        send_word(32'h88776655, 1);
        send_word(32'hCCBBAA99, 1);
        wait_done("wrap");
        eq.push_back('{a: 8'hFE, d: 32'h44332211});
        eq.push_back('{a: 8'hFF, d: 32'h88776655});
        eq.push_back('{a: 8'h00, d: 32'hCCBBAA99});
        cmp_writes("wrap");
        chk("wrap_done_pulses", 64'(done_cnt - dc0), 64'd1);

        // zero length
        rc0 = ready_cnt;
        start_load(8'h50, 9'd0);
        chk("zero_done",  64'(bus.load_done),  64'd1);
        chk("zero_busy",  64'(bus.load_busy),  64'd0);
        chk("zero_stall", 64'(bus.cpu_stall),  64'd1);
        tick();
        chk("zero_done_clear", 64'(bus.load_done), 64'd0);
        chk("zero_stall_rel",  64'(bus.cpu_stall), 64'd0);
        tick();
        chk("zero_no_ready", 64'(ready_cnt - rc0), 64'd0);
        cmp_writes("zero");

        // abort after two bytes of word 1, with a byte offered in the abort cycle
        dc0 = done_cnt;
        start_load(8'h10, 9'd3);
        send_word(32'h04030201, 0);
        send_byte(8'hAA, 0);
        send_byte(8'hBB, 0);
        bus.load_base  = 8'h80;
        bus.load_len   = 9'd0;
        bus.load_start = 1'b1;
        tick();
        bus.load_start = 1'b0;
        chk("abort_start_ignored_done", 64'(bus.load_done), 64'd0);
        chk("abort_start_ignored_busy", 64'(bus.load_busy), 64'd1);
        bus.load_abort = 1'b1;
        bus.byte_valid = 1'b1;
        bus.byte_data  = 8'hCC;
        tick();
        bus.load_abort = 1'b0;
        bus.byte_valid = 1'b0;
        chk("abort_done", 64'(bus.load_done), 64'd1);
        chk("abort_we",   64'(bus.mem_we),    64'd0);
        tick();
        chk("abort_stall_rel", 64'(bus.cpu_stall), 64'd0);
        tick();
        eq.push_back('{a: 8'h10, d: 32'h04030201});
        cmp_writes("abort");
        chk("abort_done_pulses", 64'(done_cnt - dc0), 64'd1);

        // reset mid-RECV after three bytes, then a fresh load
        bus.fetch_addr = 8'h7C;
        start_load(8'h20, 9'd1);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        send_byte(8'h33, 0);
        rst = 1'b1;
        tick();
        check_reset_outputs("midrst");
        rst = 1'b0;
        tick();
        start_load(8'h21, 9'd1);
        send_word(32'hEFBEADDE, 0);
        chk("fresh_we",    64'(bus.mem_we),    64'd1);
        chk("fresh_wdata", 64'(bus.mem_wdata), 64'hEFBEADDE);
        wait_done("fresh");
        eq.push_back('{a: 8'h21, d: 32'hEFBEADDE});
        cmp_writes("fresh");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/imem_load_ctrl.md
Name: imem_load_ctrl

Overview:
Controller that owns the single address port of the instruction memory and shares it between the CPU fetch path and a byte-serial program loader. In normal operation the fetch address passes straight through. During a load it stalls the CPU, assembles incoming bytes into 32-bit little-endian words, and writes them to consecutive word addresses. Sits between the PC/fetch logic, a host byte source (UART/debug), and the instruction memory.

Parameters:
ADDR_W, 8, word-address width of the instruction memory (256 words).
DATA_W, 32, instruction width; fixed at 4 bytes per word.

Ports:
clk  in  1  rising-edge clock.
rst  in  1  reset: synchronous, active-high.
fetch_addr  in  ADDR_W  word address from PC logic.
load_start  in  1  one-cycle request to begin a load; sampled only in IDLE.
load_base  in  ADDR_W  first word address of the load; captured with load_start.
load_len  in  ADDR_W+1  number of words (0..256); captured with load_start.
load_abort  in  1  cancel an in-progress load.
byte_valid  in  1  loader byte valid.
byte_data  in  8  loader byte.
byte_ready  out  1  controller accepts a byte this cycle.
mem_addr  out  ADDR_W  address to instruction memory.
mem_wdata  out  DATA_W  assembled write word.
mem_we  out  1  write enable, one cycle per word.
cpu_stall  out  1  freezes PC/fetch while high.
load_busy  out  1  high in RECV/WRITE.
load_done  out  1  one-cycle pulse when a load completes or is aborted.

Behaviour:
- States: IDLE, RECV, WRITE, DONE. Registered state; all outputs decoded from state and registers.
- Reset (rst=1 at a clock edge): state=IDLE, byte counter=0, word counter=0, assembly register=0. Outputs: byte_ready=0, mem_we=0, mem_wdata=0, cpu_stall=0, load_busy=0, load_done=0. mem_addr=fetch_addr, which is combinational in IDLE. Reset mid-load discards the partial word and issues no write. Memory contents are untouched.
- IDLE: mem_addr=fetch_addr, cpu_stall=0. On load_start: capture load_base into the write pointer and load_len into the remaining count. If load_len=0, go to DONE; otherwise go to RECV.
- RECV: byte_ready=1, cpu_stall=1, load_busy=1, mem_addr=write pointer. A byte is accepted when byte_valid && byte_ready.
  - Byte k (0..3) goes into bits [8k+7:8k] (little-endian).
  - The byte accepted with counter=3 completes the word; go to WRITE next cycle.
  - byte_valid low inserts wait cycles with no timeout.
- WRITE: exactly one cycle. mem_we=1, mem_wdata=assembled word, mem_addr=write pointer, byte_ready=0. Then:
  - the pointer increments modulo 2^ADDR_W (255 wraps to 0) and the remaining count decrements;
  - if the remaining count becomes 0, go to DONE; otherwise go to RECV with byte counter=0.
- DONE: one cycle. load_done=1, cpu_stall=1, mem_we=0. Go to IDLE; the stall releases on the following cycle.
- load_start while not in IDLE: ignored.
- load_abort:
  - in RECV: go to DONE next cycle; the partial word is discarded. Abort has priority over a byte accepted the same cycle (no write).
  - in WRITE: the write completes, then go to DONE.
  - in IDLE or DONE: no effect.
- Throughput: 5 cycles per word minimum (4 byte cycles + 1 write cycle). Load latency = 5·N + 1 cycles from the RECV entry.

Decomposition:
- Shared package: state encoding (IDLE=2'd0, RECV=2'd1, WRITE=2'd2, DONE=2'd3), ADDR_W/DATA_W defaults, BYTES_PER_WORD=4.
- One natural sub-module, imem_word_packer: byte counter plus shift/assembly register, with accept/clear inputs and word_full/word outputs.

Test Plan:
1. Idle passthrough: fetch_addr=0x00,0x05,0xFF → mem_addr follows in the same cycle; cpu_stall=0, mem_we=0.
2. Single-word load: base=0x03, len=1, bytes 0x83,0x21,0x40,0x00 → one mem_we at addr 0x03 with wdata=0x00402183; load_done pulse; stall low 2 cycles after the write.
3. Multi-word with wrap and gaps: base=0xFE, len=3, byte_valid toggling every other cycle → writes at 0xFE, 0xFF, 0x00 in order, each with the correct word.
4. Zero length: len=0 → IDLE→DONE→IDLE; load_done=1 for one cycle; no mem_we; byte_ready never asserted.
5. Abort: load_abort asserted after 2 bytes of word 1 (word 0 already written) → only word 0 written; load_done pulses; load_start ignored during busy.
6. Reset mid-RECV after 3 bytes → next cycle all outputs at reset values and no write; a fresh load then starts from byte 0 correctly.
